tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Programmable step sequencer that drives the 8-bit tone-enable mask (`data_in`) of the tone modulator.
- Holds a small table of {tone mask, duration} entries and plays them in order, each for a programmed number of ticks.
- Optionally loops over the table.
- Sits between the host/control logic and the modulator. The modulator's carrier gating is unchanged.

Parameters:
- DEPTH, 8, number of sequence entries (power of two, 2..16)
- TICK_DIV, 50000, clk cycles per duration tick (>=2)
- DUR_W, 8, width of per-entry duration field

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  write strobe for sequence table
- wr_addr  input  log2(DEPTH)  table entry to write
- wr_mask  input  8  tone mask for entry
- wr_dur  input  DUR_W  duration in ticks for entry
- seq_len  input  log2(DEPTH)+1  number of entries to play
- loop_en  input  1  wrap to entry 0 after last entry
- start  input  1  begin playback (level sampled per cycle, acts on IDLE only)
- stop  input  1  abort playback
- note_out  output  8  tone mask to modulator `data_in`
- busy  output  1  high while not IDLE
- step  output  log2(DEPTH)  index of entry currently playing
- done  output  1  one-cycle pulse on natural end of sequence

Behaviour:
- Reset (async, rst=1): state=IDLE, note_out=0, busy=0, step=0, done=0, tick counter=0, all table entries={0,0}.
- Table write:
  - wr_en=1 writes {wr_mask, wr_dur} to entry wr_addr on the clk edge.
  - Writes are allowed at any time.
  - During playback a write affects an entry only when that entry is next loaded; the mask and duration are latched at step load.
- Effective length L:
  - L = min(seq_len, DEPTH).
  - If L=0, start is ignored and the block stays IDLE.
- States:
  - IDLE: note_out=0, busy=0.
  - PLAY: note_out=latched mask, busy=1.
  - GAP: only when REST_GAP_EN is defined.
- IDLE -> PLAY: start=1 and stop=0 and L>0. On the next cycle: step=0, note_out=mem[0].mask, busy=1, tick counter=0, remaining ticks=mem[0].dur.
- Tick generation:
  - The tick counter runs 0..TICK_DIV-1 only while not IDLE.
  - The tick event fires when the counter is at TICK_DIV-1; the counter then wraps to 0.
- Duration:
  - Entry with dur=d holds for max(d,1) ticks, i.e. max(d,1)*TICK_DIV cycles. dur=0 is treated as 1.
  - On the final tick of an entry, the next entry is loaded on the following edge with no idle cycle.
- End of entry with step=L-1:
  - loop_en=1 (sampled at that edge): step=0, load entry 0, stay in PLAY.
  - loop_en=0: go to IDLE, note_out=0, busy=0, done=1 for exactly one cycle.
- stop=1 in PLAY or GAP:
  - Next cycle IDLE, note_out=0, busy=0, step=0, tick counter=0, no done pulse.
  - stop and start in the same cycle: stop wins.
- start while busy is ignored; playback does not restart.
- seq_len changes during playback take effect at the next end-of-entry comparison.
- Sequencing is table order only; there is no arbitration.
- done is never asserted in the same cycle as busy=1 from a new start.

Optional Feature:
- Macro: TONE_SEQUENCER_REST_GAP_EN.
- Defined:
  - After every entry (including the last entry when looping), the block enters GAP for exactly 1 tick (TICK_DIV cycles) with note_out=0, busy=1, and step unchanged.
  - It then loads the next entry.
  - No gap follows the final entry of a non-looping sequence; it goes directly to IDLE with done.
  - stop in GAP behaves as in PLAY.
- Undefined: the GAP state does not exist and entries are back-to-back.

Test Plan:
1. Reset and idle: assert rst mid-playback (TICK_DIV=4, entry0={0x01,3}) -> outputs go immediately to note_out=0x00, busy=0, step=0, done=0; start held low keeps the block IDLE.
2. Basic sequence, TICK_DIV=4, L=3, entries {0x01,2},{0x80,1},{0x3C,0}, loop_en=0, pulse start -> note_out=0x01 for 8 cycles, 0x80 for 4 cycles, 0x3C for 4 cycles (dur 0 treated as 1), then 0x00 with done=1 for exactly 1 cycle, busy=0.
3. Loop: same table, loop_en=1 -> after 0x3C, note_out returns to 0x01 with step=0 and no done; deassert loop_en during the second pass -> ends after the second 0x3C with done.
4. Stop/start priority: during step 1, assert start and stop together -> next cycle IDLE, note_out=0x00, no done; assert start with seq_len=0 -> stays IDLE.
5. Live write: while step 0 plays, write entry 1={0xAA,2} -> step 1 outputs 0xAA for 8 cycles. Rewrite entry 1 while it plays -> output unchanged until that entry is reloaded on the next loop.
6. With TONE_SEQUENCER_REST_GAP_EN: scenario 2 table, loop_en=0 -> 4 cycles of note_out=0x00 with busy=1 between 0x01→0x80 and 0x80→0x3C, none after 0x3C; done follows 0x3C directly.

Source files
------------

// File: rtl/tone_sequencer.sv
// Step sequencer driving the tone modulator's 8-bit enable mask from a {mask, duration} table.
// Optional build macro TONE_SEQUENCER_REST_GAP_EN inserts a one-tick silent GAP between entries.
module tone_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_mask,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW:0]      seq_len,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       note_out,
    output logic             busy,
    output logic [AW-1:0]    step,
    output logic             done
);

`ifdef TONE_SEQUENCER_REST_GAP_EN
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [7:0]       mem_mask [DEPTH];
    logic [DUR_W-1:0] mem_dur  [DEPTH];

    state_t           state;
    logic [CW-1:0]    tick_cnt;
    logic [DUR_W-1:0] rem;
    logic [AW:0]      eff_len;
    logic             tick;
    logic             last_step;
    logic [AW-1:0]    next_idx;
`ifdef TONE_SEQUENCER_REST_GAP_EN
    logic [AW-1:0]    gap_next;
`endif

    function automatic logic [DUR_W-1:0] dur_fix(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign eff_len = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    assign tick    = (tick_cnt == CW'(TICK_DIV - 1));
    // ">=" rather than "==" so a seq_len shrunk below the current step still ends playback
    assign last_step = ((AW+1)'(step) + (AW+1)'(1)) >= eff_len;
    assign next_idx  = last_step ? '0 : step + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_mask[i] <= '0;
                mem_dur[i]  <= '0;
            end
        end else if (wr_en) begin
            mem_mask[wr_addr] <= wr_mask;
            mem_dur[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            note_out <= '0;
            busy     <= 1'b0;
            step     <= '0;
            done     <= 1'b0;
            tick_cnt <= '0;
            rem      <= '0;
`ifdef TONE_SEQUENCER_REST_GAP_EN
            gap_next <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                if (start && !stop && eff_len != '0) begin
                    state    <= PLAY;
                    busy     <= 1'b1;
                    step     <= '0;
                    note_out <= mem_mask[0];
                    rem      <= dur_fix(mem_dur[0]);
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                if (stop) begin
                    state    <= IDLE;
                    note_out <= '0;
                    busy     <= 1'b0;
                    step     <= '0;
                    tick_cnt <= '0;
                end else if (tick) begin
                    if (state == PLAY && rem > DUR_W'(1)) begin
                        rem <= rem - DUR_W'(1);
                    end else if (state == PLAY && last_step && !loop_en) begin
                        state    <= IDLE;
                        note_out <= '0;
                        busy     <= 1'b0;
                        step     <= '0;
                        done     <= 1'b1;
                        tick_cnt <= '0;
`ifdef TONE_SEQUENCER_REST_GAP_EN
                    end else if (state == PLAY) begin
                        // next index is decided now, so loop_en/seq_len are sampled at entry end
                        state    <= GAP;
                        note_out <= '0;
                        gap_next <= next_idx;
                    end else begin
                        state    <= PLAY;
                        step     <= gap_next;
                        note_out <= mem_mask[gap_next];
                        rem      <= dur_fix(mem_dur[gap_next]);
                    end
`else
                    end else begin
                        step     <= next_idx;
                        note_out <= mem_mask[next_idx];
                        rem      <= dur_fix(mem_dur[next_idx]);
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: segment tables of expected outputs plus hand-written corner sequences.
module tb_tone_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_mask = '0;
    logic [7:0] wr_dur = '0;
    logic [3:0] seq_len = '0;
    logic       loop_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] note_out;
    logic       busy;
    logic [2:0] step;
    logic       done;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] note;
        logic       busy;
        logic [2:0] step;
        logic       done;
        int         n;
        logic       lp;
    } seg_t;
    seg_t tbl[$];

    tone_sequencer #(.DEPTH(8), .TICK_DIV(TD), .DUR_W(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_dur(wr_dur), .seq_len(seq_len), .loop_en(loop_en), .start(start), .stop(stop),
        .note_out(note_out), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [7:0] n, logic b, logic [2:0] s, logic d);
        checks++;
        if (note_out !== n || busy !== b || step !== s || done !== d) begin
            errs++;
            $display("FAIL %s @%0t: got note=%h busy=%b step=%0d done=%b, want note=%h busy=%b step=%0d done=%b",
                     nm, $time, note_out, busy, step, done, n, b, s, d);
        end
    endtask

    // check the current outputs, advance one cycle, repeat cnt times
    task automatic run(string nm, logic [7:0] n, logic b, logic [2:0] s, logic d, int cnt);
        for (int i = 0; i < cnt; i++) begin
            chk(nm, n, b, s, d);
            cyc();
        end
    endtask

    task automatic gap(logic [2:0] s);
`ifdef TONE_SEQUENCER_REST_GAP_EN
        run("gap", 8'h00, 1'b1, s, 1'b0, TD);
`else
        if (s > 3'd7) run("nogap", 8'h00, 1'b0, s, 1'b0, 0);
`endif
    endtask

    task automatic wr(logic [2:0] a, logic [7:0] m, logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_dur = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic void add(logic [7:0] n, logic b, logic [2:0] s, logic d, int cnt, logic lp);
        tbl.push_back('{note: n, busy: b, step: s, done: d, n: cnt, lp: lp});
    endfunction

    function automatic void add_gap(logic [2:0] s, logic lp);
`ifdef TONE_SEQUENCER_REST_GAP_EN
        add(8'h00, 1'b1, s, 1'b0, TD, lp);
`else
        if (s > 3'd7) add(8'h00, 1'b0, s, 1'b0, 0, lp);
`endif
    endfunction

    task automatic run_tbl(string nm);
        foreach (tbl[i]) begin
            loop_en = tbl[i].lp;
            run($sformatf("%s[%0d]", nm, i), tbl[i].note, tbl[i].busy, tbl[i].step, tbl[i].done, tbl[i].n);
        end
    endtask

    initial begin
        // reset state while rst held
        cyc();
        run("reset", 8'h00, 1'b0, 3'd0, 1'b0, 2);
        rst = 1'b0;

        // 1: async reset mid-playback, then idle and cleared table
        wr(3'd0, 8'h01, 8'd3);
        seq_len = 4'd1;
        kick();
        run("s1 play", 8'h01, 1'b1, 3'd0, 1'b0, 3);
        rst = 1'b1;
        #1;
        chk("s1 async rst", 8'h00, 1'b0, 3'd0, 1'b0);
        cyc();
        rst = 1'b0;
        run("s1 idle", 8'h00, 1'b0, 3'd0, 1'b0, 3);
        kick();
        run("s1 cleared", 8'h00, 1'b1, 3'd0, 1'b0, TD);
        run("s1 cleared done", 8'h00, 1'b0, 3'd0, 1'b1, 1);

        // 2: basic three-entry sequence, dur 0 plays as 1 tick
        wr(3'd0, 8'h01, 8'd2);
        wr(3'd1, 8'h80, 8'd1);
        wr(3'd2, 8'h3C, 8'd0);
        seq_len = 4'd3;
        loop_en = 1'b0;
        tbl.delete();
        add(8'h01, 1'b1, 3'd0, 1'b0, 2*TD, 1'b0);
        add_gap(3'd0, 1'b0);
        add(8'h80, 1'b1, 3'd1, 1'b0, TD, 1'b0);
        add_gap(3'd1, 1'b0);
        add(8'h3C, 1'b1, 3'd2, 1'b0, TD, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b1, 1, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b0, 2, 1'b0);
        kick();
        run_tbl("s2");

        // 3: loop once, drop loop_en during second pass
        loop_en = 1'b1;
        tbl.delete();
        add(8'h01, 1'b1, 3'd0, 1'b0, 2*TD, 1'b1);
        add_gap(3'd0, 1'b1);
        add(8'h80, 1'b1, 3'd1, 1'b0, TD, 1'b1);
        add_gap(3'd1, 1'b1);
        add(8'h3C, 1'b1, 3'd2, 1'b0, TD, 1'b1);
        add_gap(3'd2, 1'b1);
        add(8'h01, 1'b1, 3'd0, 1'b0, 2*TD, 1'b0);
        add_gap(3'd0, 1'b0);
        add(8'h80, 1'b1, 3'd1, 1'b0, TD, 1'b0);
        add_gap(3'd1, 1'b0);
        add(8'h3C, 1'b1, 3'd2, 1'b0, TD, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b1, 1, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b0, 2, 1'b0);
        kick();
        run_tbl("s3");

        // 4: stop beats start; zero length never starts; oversize length clamps to DEPTH
        kick();
        run("s4 s0", 8'h01, 1'b1, 3'd0, 1'b0, 2*TD);
        gap(3'd0);
        run("s4 s1", 8'h80, 1'b1, 3'd1, 1'b0, 1);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        run("s4 stopped", 8'h00, 1'b0, 3'd0, 1'b0, 3);
        seq_len = 4'd0;
        start = 1'b1;
        run("s4 len0", 8'h00, 1'b0, 3'd0, 1'b0, 3);
        start = 1'b0;
        seq_len = 4'd15;
        kick();
        run("s4 clamp s0", 8'h01, 1'b1, 3'd0, 1'b0, 2*TD);
        gap(3'd0);
        run("s4 clamp s1", 8'h80, 1'b1, 3'd1, 1'b0, TD);
        gap(3'd1);
        run("s4 clamp s2", 8'h3C, 1'b1, 3'd2, 1'b0, TD);
        gap(3'd2);
        run("s4 clamp s3", 8'h00, 1'b1, 3'd3, 1'b0, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        run("s4 clamp stop", 8'h00, 1'b0, 3'd0, 1'b0, 1);

        // 5: live writes latch only at step load
        seq_len = 4'd2;
        loop_en = 1'b1;
        kick();
        wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 8'hAA; wr_dur = 8'd2;
        run("s5 w1", 8'h01, 1'b1, 3'd0, 1'b0, 1);
        wr_en = 1'b0;
        run("s5 s0", 8'h01, 1'b1, 3'd0, 1'b0, 2*TD-1);
        gap(3'd0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 8'h55; wr_dur = 8'd1;
        run("s5 aa w2", 8'hAA, 1'b1, 3'd1, 1'b0, 1);
        wr_en = 1'b0;
        run("s5 aa", 8'hAA, 1'b1, 3'd1, 1'b0, 2*TD-1);
        gap(3'd1);
        run("s5 loop s0", 8'h01, 1'b1, 3'd0, 1'b0, 2*TD);
        gap(3'd0);
        run("s5 reload", 8'h55, 1'b1, 3'd1, 1'b0, TD);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        run("s5 stopped", 8'h00, 1'b0, 3'd0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
